// File: rtl/dcache_wb_queue_pkg.sv
// rtl/dcache_wb_queue_pkg.sv - shared encodings and helpers for the data-cache write-back queue
package dcache_wb_queue_pkg;

    // AXI AxSIZE encodings for the two supported data widths
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [2:0] SIZE_8B = 3'b011;

    // Drain FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } drain_state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wbq_entry_ram.sv
// rtl/wbq_entry_ram.sv - register-array storage for the write-back queue entries
module wbq_entry_ram
    import dcache_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PTR_W      = clog2(DEPTH),
    parameter int BEAT_W     = (LINE_WORDS > 1) ? clog2(LINE_WORDS) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [PTR_W-1:0]             wr_ptr,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic                         wr_uncache,
    input  logic [DATA_W/8-1:0]          wr_strb,
    input  logic [LINE_WORDS*DATA_W-1:0] wr_line,
    input  logic                         clr_en,
    input  logic [PTR_W-1:0]             clr_ptr,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [BEAT_W-1:0]            rd_word,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_uncache,
    output logic [DATA_W/8-1:0]          rd_strb,
    output logic [DATA_W-1:0]            rd_data,
    output logic [ADDR_W-1:0]            ent_addr [DEPTH],
    output logic [DEPTH-1:0]             ent_uncache,
    output logic [DEPTH-1:0]             ent_valid
);

    logic [ADDR_W-1:0]                   mem_addr [DEPTH];
    logic [DEPTH-1:0]                    mem_uncache;
    logic [DATA_W/8-1:0]                 mem_strb [DEPTH];
    logic [LINE_WORDS-1:0][DATA_W-1:0]   mem_line [DEPTH];
    logic [DEPTH-1:0]                    valid_q;

    // Occupancy bits: set on enqueue, cleared once the head's B response completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_ptr] <= 1'b0;
            if (wr_en)  valid_q[wr_ptr]  <= 1'b1;
        end
    end

    // Entry payload; contents are meaningless until the valid bit is set, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_addr[wr_ptr]    <= wr_addr;
            mem_uncache[wr_ptr] <= wr_uncache;
            mem_strb[wr_ptr]    <= wr_strb;
            mem_line[wr_ptr]    <= wr_line;
        end
    end

    // Combinational head read with word select, plus per-entry taps for the query comparators
    always_comb begin
        rd_addr     = mem_addr[rd_ptr];
        rd_uncache  = mem_uncache[rd_ptr];
        rd_strb     = mem_strb[rd_ptr];
        rd_data     = mem_line[rd_ptr][rd_word];
        ent_uncache = mem_uncache;
        ent_valid   = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = mem_addr[i];
        end
    end

endmodule

// File: rtl/dcache_wb_queue.sv
// rtl/dcache_wb_queue.sv - multi-entry write-back queue draining victim lines and uncached stores to AXI
module dcache_wb_queue
    import dcache_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic                          push_uncache,
    input  logic [DATA_W/8-1:0]           push_strb,
    input  logic [LINE_WORDS*DATA_W-1:0]  push_line,
    input  logic [ADDR_W-1:0]             query_addr,
    output logic                          query_hit,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          empty,
    output logic                          w_req,
    input  logic                          w_rdy,
    output logic [ADDR_W-1:0]             w_addr,
    output logic [7:0]                    w_length,
    output logic [2:0]                    w_size,
    output logic                          w_data_req,
    input  logic                          w_data_ready,
    output logic [DATA_W-1:0]             w_data_AXI,
    output logic [DATA_W/8-1:0]           w_strb,
    output logic                          w_last,
    input  logic                          b_valid,
    output logic                          b_ready
);

    localparam int PTR_W    = clog2(DEPTH);
    localparam int CNT_W    = clog2(DEPTH + 1);
    localparam int BEAT_W   = (LINE_WORDS > 1) ? clog2(LINE_WORDS) : 1;
    localparam int STRB_W   = DATA_W / 8;
    localparam int LINE_OFF = clog2(LINE_WORDS * DATA_W / 8);

    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'((64'd1 << LINE_OFF) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [7:0]        LINE_LEN   = 8'(LINE_WORDS - 1);
    localparam logic [2:0]        BEAT_SIZE  = (DATA_W == 64) ? SIZE_8B : SIZE_4B;
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);

    drain_state_t        state, state_nxt;
    logic [PTR_W-1:0]    head_ptr, tail_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [BEAT_W-1:0]   beat;

    logic                push_fire, pop_fire, is_last;
    logic [ADDR_W-1:0]   head_addr;
    logic                head_uncache;
    logic [STRB_W-1:0]   head_strb;
    logic [DATA_W-1:0]   head_data;
    logic [ADDR_W-1:0]   ent_addr [DEPTH];
    logic [DEPTH-1:0]    ent_uncache;
    logic [DEPTH-1:0]    ent_valid;

    assign push_ready = (cnt != CNT_FULL);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = (state == ST_B) && b_valid;
    assign count      = cnt;
    assign empty      = (cnt == '0);
    assign is_last    = head_uncache ? (beat == '0) : (beat == LAST_BEAT);

    wbq_entry_ram #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PTR_W      (PTR_W),
        .BEAT_W     (BEAT_W)
    ) u_ram (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (push_fire),
        .wr_ptr      (tail_ptr),
        .wr_addr     (push_addr),
        .wr_uncache  (push_uncache),
        .wr_strb     (push_strb),
        .wr_line     (push_line),
        .clr_en      (pop_fire),
        .clr_ptr     (head_ptr),
        .rd_ptr      (head_ptr),
        .rd_word     (beat),
        .rd_addr     (head_addr),
        .rd_uncache  (head_uncache),
        .rd_strb     (head_strb),
        .rd_data     (head_data),
        .ent_addr    (ent_addr),
        .ent_uncache (ent_uncache),
        .ent_valid   (ent_valid)
    );

    // Pointers wrap naturally; count tracks occupancy so full and empty are unambiguous
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (push_fire) tail_ptr <= tail_ptr + 1'b1;
            if (pop_fire)  head_ptr <= head_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Drain FSM next state: one AW / W burst / B round trip per head entry
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cnt != '0)                  state_nxt = ST_AW;
            ST_AW:   if (w_rdy)                      state_nxt = ST_W;
            ST_W:    if (is_last && w_data_ready)    state_nxt = ST_B;
            ST_B:    if (b_valid)                    state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    // Beat counter: cleared on AW acceptance, advanced on each accepted W beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat <= '0;
        end else if (state == ST_AW && w_rdy) begin
            beat <= '0;
        end else if (state == ST_W && w_data_ready && !is_last) begin
            beat <= beat + 1'b1;
        end
    end

    // AXI channel outputs, driven only in their own state so they are zero elsewhere
    always_comb begin
        w_req      = 1'b0;
        w_addr     = '0;
        w_length   = '0;
        w_size     = '0;
        w_data_req = 1'b0;
        w_data_AXI = '0;
        w_strb     = '0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        case (state)
            ST_AW: begin
                w_req    = 1'b1;
                w_addr   = head_uncache ? head_addr : (head_addr & LINE_MASK);
                w_length = head_uncache ? 8'd0 : LINE_LEN;
                w_size   = BEAT_SIZE;
            end
            ST_W: begin
                w_data_req = 1'b1;
                w_data_AXI = head_data;
                w_strb     = head_uncache ? head_strb : {STRB_W{1'b1}};
                w_last     = is_last;
            end
            ST_B: begin
                b_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Line-address match against every occupied cached entry, head included until its B completes
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && !ent_uncache[i] &&
                ((ent_addr[i] & LINE_MASK) == (query_addr & LINE_MASK))) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_queue.sv
// tb/tb_dcache_wb_queue.sv - scoreboard bench for dcache_wb_queue
module tb_dcache_wb_queue;

    localparam int DEPTH = 4;
    localparam int LW    = 16;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              push_valid;
    logic              push_ready;
    logic [AW-1:0]     push_addr;
    logic              push_uncache;
    logic [SW-1:0]     push_strb;
    logic [LW*DW-1:0]  push_line;
    logic [AW-1:0]     query_addr;
    logic              query_hit;
    logic [2:0]        count;
    logic              empty;
    logic              w_req;
    logic              w_rdy;
    logic [AW-1:0]     w_addr;
    logic [7:0]        w_length;
    logic [2:0]        w_size;
    logic              w_data_req;
    logic              w_data_ready;
    logic [DW-1:0]     w_data_AXI;
    logic [SW-1:0]     w_strb;
    logic              w_last;
    logic              b_valid;
    logic              b_ready;

    dcache_wb_queue #(
        .DEPTH(DEPTH), .LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_uncache(push_uncache), .push_strb(push_strb), .push_line(push_line),
        .query_addr(query_addr), .query_hit(query_hit),
        .count(count), .empty(empty),
        .w_req(w_req), .w_rdy(w_rdy), .w_addr(w_addr), .w_length(w_length), .w_size(w_size),
        .w_data_req(w_data_req), .w_data_ready(w_data_ready), .w_data_AXI(w_data_AXI),
        .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int b_done  = 0;

    logic [42:0] aw_q [$];
    logic [36:0] w_q  [$];
    logic [42:0] exp_aw;
    logic [36:0] exp_w;

    bit aw_en = 1'b0;
    bit w_en  = 1'b0;
    bit b_en  = 1'b0;
    bit rnd   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave-side ready/response driver, updated just after each rising edge
    initial begin
        w_rdy        = 1'b0;
        w_data_ready = 1'b0;
        b_valid      = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            w_rdy        = aw_en && (!rnd || ($urandom_range(0, 1) == 1));
            w_data_ready = w_en  && (!rnd || ($urandom_range(0, 2) != 0));
            b_valid      = b_en  && (!rnd || ($urandom_range(0, 1) == 1));
        end
    end

    // Monitor: every accepted AW / W transfer is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rstn) begin
            if (w_req && w_rdy) begin
                if (aw_q.size() == 0) check_eq("aw_unexpected", 1, 0);
                else begin
                    exp_aw = aw_q.pop_front();
                    check_eq("aw_addr_len_size", {w_addr, w_length, w_size}, exp_aw);
                end
            end
            if (w_data_req && w_data_ready) begin
                if (w_q.size() == 0) check_eq("w_unexpected", 1, 0);
                else begin
                    exp_w = w_q.pop_front();
                    check_eq("w_data_strb_last", {w_data_AXI, w_strb, w_last}, exp_w);
                end
            end
            if (b_ready && b_valid) b_done++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance
    task automatic do_push(input logic [AW-1:0] a, input bit unc, input logic [SW-1:0] s,
                           input logic [LW*DW-1:0] line);
        bit ok;
        push_valid   = 1'b1;
        push_addr    = a;
        push_uncache = unc;
        push_strb    = s;
        push_line    = line;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (push_ready) ok = 1'b1;
        end
        if (!ok) check_eq("push_timeout", 0, 1);
        else if (unc) begin
            aw_q.push_back({a, 8'd0, 3'b010});
            w_q.push_back({line[DW-1:0], s, 1'b1});
        end else begin
            aw_q.push_back({a & 32'hFFFF_FFC0, 8'd15, 3'b010});
            for (int i = 0; i < LW; i++)
                w_q.push_back({line[i*DW +: DW], 4'hF, (i == LW - 1)});
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (empty && !w_req && !w_data_req && !b_ready) ok = 1'b1;
        end
        check_eq(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (b_ready) ok = 1'b1;
        end
        check_eq(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    logic [LW*DW-1:0] line;
    bit seen;

    initial begin
        rstn = 1'b0; push_valid = 1'b0; push_addr = '0; push_uncache = 1'b0;
        push_strb = '0; push_line = '0; query_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_push_ready", push_ready, 1);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_axi_valids", {w_req, w_data_req, b_ready, w_last}, 0);
        check_eq("rst_query_hit", query_hit, 0);
        @(posedge clk); #1; rstn = 1'b1;

        // Single cached line
        aw_en = 1; w_en = 1; b_en = 1;
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hA0 + i;
        do_push(32'h1000_0040, 1'b0, 4'hF, line);
        wait_idle("line_drained", 200);
        check_eq("line_count", count, 0);
        check_eq("line_b_done", b_done, 1);

        // Uncached store
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = $urandom();
        line[DW-1:0] = 32'h1200_0000;
        do_push(32'h1FD0_0003, 1'b1, 4'b1000, line);
        wait_idle("unc_drained", 100);

        // Fill to full with AW held off
        aw_en = 0; b_en = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < LW; i++) line[i*DW +: DW] = {8'(k), 24'(i)};
            do_push(32'h3000_0000 + 32'(k) * 32'h40, 1'b0, 4'hF, line);
        end
        @(negedge clk);
        check_eq("full_count", count, 4);
        check_eq("full_push_ready", push_ready, 0);
        @(posedge clk); #1;
        push_valid = 1'b1; push_addr = 32'h3000_1000; push_uncache = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_5th_blocked", push_ready, 0);
        end
        @(posedge clk); #1; push_valid = 1'b0;
        @(negedge clk);
        check_eq("full_count_hold", count, 4);
        @(posedge clk); #1;
        aw_en = 1;
        wait_b("full_reach_b");
        b_en = 1;
        @(negedge clk);
        check_eq("full_ready_during_b", push_ready, 0);
        @(posedge clk); #1; b_en = 0;
        @(negedge clk);
        check_eq("full_ready_after_b", push_ready, 1);
        check_eq("full_count_after_b", count, 3);
        @(posedge clk); #1; b_en = 1;
        wait_idle("full_drained", 400);

        // Simultaneous enqueue and B completion at count 2
        b_en = 0;
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hC100_0000 + i;
        do_push(32'h4000_0000, 1'b0, 4'hF, line);
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hC200_0000 + i;
        do_push(32'h4000_0040, 1'b0, 4'hF, line);
        wait_b("sim_reach_b");
        @(negedge clk);
        check_eq("sim_count_pre", count, 2);
        @(posedge clk); #1;
        b_en = 1;
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hC300_0000 + i;
        do_push(32'h4000_0080, 1'b0, 4'hF, line);
        @(negedge clk);
        check_eq("sim_count_post", count, 2);
        @(posedge clk); #1;
        wait_idle("sim_drained", 200);

        // Query port
        aw_en = 0; b_en = 0;
        do_push(32'h2000_0080, 1'b1, 4'hF, line);
        @(negedge clk); query_addr = 32'h2000_0080; #1;
        check_eq("query_uncached", query_hit, 0);
        @(posedge clk); #1;
        aw_en = 1; b_en = 1;
        wait_idle("query_unc_drained", 100);
        b_en = 0;
        do_push(32'h2000_0080, 1'b0, 4'hF, line);
        @(negedge clk); query_addr = 32'h2000_00BC; #1;
        check_eq("query_same_line", query_hit, 1);
        query_addr = 32'h2000_00C0; #1;
        check_eq("query_next_line", query_hit, 0);
        query_addr = 32'h2000_00BC;
        wait_b("query_reach_b");
        @(negedge clk);
        check_eq("query_hit_in_b", query_hit, 1);
        @(posedge clk); #1; b_en = 1;
        @(negedge clk);
        check_eq("query_hit_b_cycle", query_hit, 1);
        @(posedge clk); #1; b_en = 0;
        @(negedge clk);
        check_eq("query_hit_after_b", query_hit, 0);
        @(posedge clk); #1;
        wait_idle("query_drained", 50);

        // Random back-pressure
        rnd = 1; aw_en = 1; w_en = 1; b_en = 1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < LW; i++) line[i*DW +: DW] = $urandom();
            if (k == 2) do_push($urandom(), 1'b1, 4'($urandom_range(1, 15)), line);
            else        do_push({$urandom()} & 32'hFFFF_FFC0, 1'b0, 4'hF, line);
        end
        wait_idle("rand_drained", 1500);
        rnd = 0;

        // Reset in the middle of a W burst
        w_en = 0; b_en = 0;
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = $urandom();
        do_push(32'h5000_0000, 1'b0, 4'hF, line);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (w_data_req) seen = 1'b1;
        end
        check_eq("rst_reach_w", seen, 1);
        #2; rstn = 1'b0; #1;
        check_eq("midrst_valids", {w_req, w_data_req, w_last, b_ready}, 0);
        check_eq("midrst_data", {w_addr, w_data_AXI, w_strb}, 0);
        check_eq("midrst_ready_empty", {push_ready, empty, count}, {1'b1, 1'b1, 3'd0});
        aw_q.delete(); w_q.delete();
        w_en = 1; b_en = 1;
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_empty", empty, 1);
        check_eq("post_rst_idle", {w_req, w_data_req, query_hit}, 0);
        @(posedge clk); #1;
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hD000_0000 + i;
        do_push(32'h5000_0040, 1'b0, 4'hF, line);
        wait_idle("post_rst_drained", 200);

        check_eq("aw_leftover", aw_q.size(), 0);
        check_eq("w_leftover", w_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
